// File: rtl/ysyx_23060124_pipe_elastic_buf.sv
// Elastic pipeline buffer: DEPTH-entry FIFO with valid/ready handshakes on both sides,
// synchronous flush and optional zeroing of o_data while no entry is valid.
module ysyx_23060124_pipe_elastic_buf #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 2,
    parameter bit ZERO_BUBBLE = 1,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Ready comes only from registered occupancy, so a same-cycle pop never frees a slot.
    assign o_ready = reset & (count_q < CW'(DEPTH));
    assign o_valid = (count_q != '0);
    assign o_count = count_q;
    assign o_data  = (o_valid || !ZERO_BUBBLE) ? mem_q[rd_ptr_q] : '0;

    assign push = i_valid & o_ready & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_pipe_elastic_buf.sv
// Directed bench for the elastic buffer: three instances (DEPTH 2/4/3) exercised in turn.
module tb_ysyx_23060124_pipe_elastic_buf;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance a: DEPTH=2, ZERO_BUBBLE=1
    logic        fl_a = 0, iv_a = 0, ird_a = 0, ov_a, ord_a;
    logic [63:0] id_a = 0, od_a;
    logic [1:0]  oc_a;
    // Instance b: DEPTH=4, ZERO_BUBBLE=1
    logic        fl_b = 0, iv_b = 0, ird_b = 0, ov_b, ord_b;
    logic [63:0] id_b = 0, od_b;
    logic [2:0]  oc_b;
    // Instance c: DEPTH=3, ZERO_BUBBLE=0
    logic        fl_c = 0, iv_c = 0, ird_c = 0, ov_c, ord_c;
    logic [63:0] id_c = 0, od_c;
    logic [1:0]  oc_c;

    ysyx_23060124_pipe_elastic_buf #(.WIDTH(64), .DEPTH(2), .ZERO_BUBBLE(1)) u_a (
        .clock(clock), .reset(reset), .i_flush(fl_a), .i_valid(iv_a), .o_ready(ord_a),
        .i_data(id_a), .o_valid(ov_a), .i_ready(ird_a), .o_data(od_a), .o_count(oc_a));
    ysyx_23060124_pipe_elastic_buf #(.WIDTH(64), .DEPTH(4), .ZERO_BUBBLE(1)) u_b (
        .clock(clock), .reset(reset), .i_flush(fl_b), .i_valid(iv_b), .o_ready(ord_b),
        .i_data(id_b), .o_valid(ov_b), .i_ready(ird_b), .o_data(od_b), .o_count(oc_b));
    ysyx_23060124_pipe_elastic_buf #(.WIDTH(64), .DEPTH(3), .ZERO_BUBBLE(0)) u_c (
        .clock(clock), .reset(reset), .i_flush(fl_c), .i_valid(iv_c), .o_ready(ord_c),
        .i_data(id_c), .o_valid(ov_c), .i_ready(ird_c), .o_data(od_c), .o_count(oc_c));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] dval;
    int          npush, nxt;
    bit          push_ok, pop_ok;

    initial begin
        // 1. reset then single push
        #1 reset = 1'b0;
        repeat (3) step();
        chk("t1_rst_ov", ov_a, 0);
        chk("t1_rst_od", od_a, 0);
        chk("t1_rst_oc", oc_a, 0);
        chk("t1_rst_ord", ord_a, 0);
        chk("t1_rst_oc_b", oc_b, 0);
        reset = 1'b1;
        #1;
        chk("t1_ord_up", ord_a, 1);
        id_a = 64'h0000_0000_8000_0004; iv_a = 1; ird_a = 1;
        step();
        iv_a = 0;
        chk("t1_ov", ov_a, 1);
        chk("t1_od", od_a, 64'h0000_0000_8000_0004);
        chk("t1_oc", oc_a, 1);
        step();
        chk("t1_pop_ov", ov_a, 0);
        chk("t1_pop_oc", oc_a, 0);
        chk("t1_pop_od", od_a, 0);

        // 2. continuous streaming 1..100
        for (int i = 1; i <= 100; i++) begin
            id_a = 64'(i); iv_a = 1;
            chk("t2_ord", ord_a, 1);
            step();
            chk("t2_od", od_a, 64'(i));
        end
        iv_a = 0;
        chk("t2_oc_last", oc_a, 1);
        step();
        chk("t2_drain_ov", ov_a, 0);
        ird_a = 0;

        // 3. backpressure and full, DEPTH=4
        ird_b = 0;
        for (int i = 0; i < 4; i++) begin
            id_b = 64'hA0 + 64'(i); iv_b = 1;
            step();
        end
        chk("t3_full_oc", oc_b, 4);
        chk("t3_full_ord", ord_b, 0);
        chk("t3_full_od", od_b, 64'hA0);
        id_b = 64'hE0; iv_b = 1;
        step();
        chk("t3_stall_oc", oc_b, 4);
        chk("t3_stall_od", od_b, 64'hA0);
        ird_b = 1;
        step();
        chk("t3_pop1_od", od_b, 64'hA1);
        chk("t3_pop1_oc", oc_b, 3);
        chk("t3_pop1_ord", ord_b, 1);
        step();
        iv_b = 0;
        chk("t3_pop2_od", od_b, 64'hA2);
        chk("t3_pop2_oc", oc_b, 3);
        step();
        chk("t3_pop3_od", od_b, 64'hA3);
        chk("t3_pop3_oc", oc_b, 2);
        step();
        chk("t3_e_od", od_b, 64'hE0);
        chk("t3_e_oc", oc_b, 1);
        step();
        chk("t3_empty_ov", ov_b, 0);
        chk("t3_empty_od", od_b, 0);
        ird_b = 0;

        // 4. DEPTH=3 wrap, push-push-pop pattern, then drain
        npush = 0; nxt = 1;
        for (int cyc = 0; cyc < 80 && (npush < 10 || q.size() > 0); cyc++) begin
            iv_c  = (npush < 10) && (cyc % 3 != 2);
            ird_c = (cyc % 3 == 2) || (npush >= 10);
            dval  = 64'h100 + 64'(nxt);
            id_c  = dval;
            chk("t4_ord", ord_c, (q.size() < 3) ? 1 : 0);
            push_ok = iv_c && (q.size() < 3);
            pop_ok  = ird_c && (q.size() > 0);
            step();
            if (pop_ok) void'(q.pop_front());
            if (push_ok) begin
                q.push_back(dval);
                nxt++;
                npush++;
            end
            chk("t4_oc", oc_c, 64'(q.size()));
            chk("t4_oc_le3", (oc_c <= 3) ? 1 : 0, 1);
            chk("t4_ov", ov_c, (q.size() > 0) ? 1 : 0);
            if (q.size() > 0) chk("t4_od", od_c, q[0]);
        end
        iv_c = 0; ird_c = 0;
        chk("t4_pushes", npush, 10);
        chk("t4_drained", q.size(), 0);

        // 5. flush with simultaneous push/pop
        for (int i = 0; i < 3; i++) begin
            id_b = 64'h11 * 64'(i + 1); iv_b = 1;
            step();
        end
        chk("t5_pre_oc", oc_b, 3);
        fl_b = 1; iv_b = 1; id_b = 64'hDEAD; ird_b = 1;
        step();
        fl_b = 0; iv_b = 0;
        chk("t5_oc", oc_b, 0);
        chk("t5_ov", ov_b, 0);
        chk("t5_od", od_b, 0);
        id_b = 64'h55; iv_b = 1; ird_b = 0;
        step();
        iv_b = 0;
        chk("t5_new_od", od_b, 64'h55);
        chk("t5_new_oc", oc_b, 1);
        ird_b = 1;
        step();
        ird_b = 0;
        chk("t5_pop_oc", oc_b, 0);
        id_c = 64'h9; iv_c = 1;
        step();
        iv_c = 0; fl_c = 1; ird_c = 1;
        chk("t5c_pre_ov", ov_c, 1);
        step();
        fl_c = 0; ird_c = 0;
        chk("t5c_ov", ov_c, 0);
        chk("t5c_oc", oc_c, 0);

        // 6. asynchronous reset mid-stream
        ird_a = 0;
        id_a = 64'h61; iv_a = 1;
        step();
        id_a = 64'h62;
        step();
        iv_a = 0;
        chk("t6_full_oc", oc_a, 2);
        chk("t6_full_ord", ord_a, 0);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_ov", ov_a, 0);
        chk("t6_async_oc", oc_a, 0);
        chk("t6_async_ord", ord_a, 0);
        chk("t6_async_od", od_a, 0);
        #1 reset = 1'b1;
        #1;
        chk("t6_rel_ov", ov_a, 0);
        chk("t6_rel_ord", ord_a, 1);
        id_a = 64'h77; iv_a = 1; ird_a = 1;
        step();
        iv_a = 0;
        chk("t6_new_od", od_a, 64'h77);
        chk("t6_new_oc", oc_a, 1);
        step();
        chk("t6_end_ov", ov_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
